// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared LDPC decoder constants, transmit FSM states and beat-count helper
package ldpc_pkg;
  localparam int ROW_NUMBER = 16;
  localparam int WIDTH = 4;
  localparam int LOOP_MAX = 20;
  localparam int LOOP_W = 7;
  typedef enum logic {IDLE, SEND} tx_state_t;
  function automatic int nbeat(input int n, input int w);
    return (n + w - 1) / w;
  endfunction
endpackage

// File: rtl/ldpc_estimate_tx.sv
// ldpc_estimate_tx: captures the decoded vector on decode termination and streams it out in beats
module ldpc_estimate_tx #(
  parameter int ROW_NUMBER = ldpc_pkg::ROW_NUMBER,
  parameter int OUT_WIDTH = ldpc_pkg::WIDTH,
  parameter int LOOP_MAX = ldpc_pkg::LOOP_MAX
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic [ROW_NUMBER-1:0]     estimate,
  input  logic                      dec_val,
  input  logic [ldpc_pkg::LOOP_W-1:0] r_loop,
  output logic [OUT_WIDTH-1:0]      o_data,
  output logic                      o_val,
  input  logic                      i_rdy,
  output logic                      o_last,
  output logic                      o_conv,
  output logic [ldpc_pkg::LOOP_W-1:0] o_loop,
  output logic                      o_drop
);
  import ldpc_pkg::*;
  localparam int NBEAT = nbeat(ROW_NUMBER, OUT_WIDTH);
  localparam int PW = NBEAT * OUT_WIDTH;
  localparam int IW = NBEAT > 1 ? $clog2(NBEAT) : 1;
  tx_state_t state_q, state_d;
  logic term_q, term_d, conv_q, conv_d, drop_q, drop_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] buf_q, buf_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic ev, acc, last, load;
  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q <= IDLE;
      term_q <= 1'b0;
      conv_q <= 1'b0;
      drop_q <= 1'b0;
      idx_q <= '0;
      buf_q <= '0;
      loop_q <= '0;
    end else begin
      state_q <= state_d;
      term_q <= term_d;
      conv_q <= conv_d;
      drop_q <= drop_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
      loop_q <= loop_d;
    end
  end
  // buffer shifts right one beat per acceptance; padding bits above ROW_NUMBER load as 0
  always_comb begin
    term_d = dec_val | (r_loop == LOOP_W'(LOOP_MAX));
    ev = term_d & ~term_q;
    acc = (state_q == SEND) & i_rdy;
    last = idx_q == IW'(NBEAT - 1);
    load = ev & ((state_q == IDLE) | (acc & last));
    drop_d = ev & (state_q == SEND) & ~(acc & last);
    state_d = load ? SEND : (acc & last) ? IDLE : state_q;
    idx_d = load ? '0 : acc ? IW'(idx_q + 1'b1) : idx_q;
    buf_d = load ? PW'(estimate) : acc ? buf_q >> OUT_WIDTH : buf_q;
    conv_d = load ? dec_val : conv_q;
    loop_d = load ? r_loop : loop_q;
  end
  assign o_val = state_q == SEND;
  assign o_data = buf_q[OUT_WIDTH-1:0];
  assign o_last = o_val & last;
  assign o_conv = conv_q;
  assign o_loop = loop_q;
  assign o_drop = drop_q;
endmodule

// File: tb/tb_ldpc_estimate_tx.sv
// tb_ldpc_estimate_tx: scoreboard bench for a 16-bit and a 10-bit instance of the beat streamer
module tb_ldpc_estimate_tx;
  typedef struct packed {logic [3:0] d; logic l; logic c; logic [6:0] n;} exp_t;
  logic clk = 1'b0, xrst = 1'b1, i_rdy = 1'b1;
  logic [15:0] est_a = '0;
  logic [9:0] est_b = '0;
  logic dec_a = 1'b0, dec_b = 1'b0;
  logic [6:0] loop_a = '0, loop_b = '0;
  logic [3:0] data_a, data_b;
  logic val_a, val_b, last_a, last_b, conv_a, conv_b, drop_a, drop_b;
  logic [6:0] oloop_a, oloop_b;
  exp_t qa[$], qb[$];
  int n_vec = 0, n_err = 0, acc_a = 0, drops_a = 0, exp_drops = 0;
  always #5 clk = ~clk;
  ldpc_estimate_tx #(.ROW_NUMBER(16), .OUT_WIDTH(4), .LOOP_MAX(20)) dut_a (
    .clk(clk), .xrst(xrst), .estimate(est_a), .dec_val(dec_a), .r_loop(loop_a),
    .o_data(data_a), .o_val(val_a), .i_rdy(i_rdy), .o_last(last_a), .o_conv(conv_a),
    .o_loop(oloop_a), .o_drop(drop_a));
  ldpc_estimate_tx #(.ROW_NUMBER(10), .OUT_WIDTH(4), .LOOP_MAX(20)) dut_b (
    .clk(clk), .xrst(xrst), .estimate(est_b), .dec_val(dec_b), .r_loop(loop_b),
    .o_data(data_b), .o_val(val_b), .i_rdy(i_rdy), .o_last(last_b), .o_conv(conv_b),
    .o_loop(oloop_b), .o_drop(drop_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] beat(input logic [15:0] e, input int k, input int nbits);
    logic [15:0] m;
    m = e & ((16'h1 << nbits) - 16'h1);
    if (nbits == 16) m = e;
    return m[k*4 +: 4];
  endfunction
  task automatic push_a(input logic [15:0] e, input logic c, input logic [6:0] n);
    for (int k = 0; k < 4; k++) qa.push_back('{beat(e, k, 16), k == 3, c, n});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 && !val_a && !val_b) done = 1'b1;
    end
    chk("idle_timeout", done, 1'b1);
  endtask
  always @(negedge clk) if (!xrst) begin
    if (val_a) begin
      if (qa.size() == 0) chk("a_spurious_beat", 1, 0);
      else begin
        chk("a_data", data_a, qa[0].d);
        chk("a_last", last_a, qa[0].l);
        chk("a_conv", conv_a, qa[0].c);
        chk("a_loop", oloop_a, qa[0].n);
        if (i_rdy) begin
          void'(qa.pop_front());
          acc_a++;
        end
      end
    end else if (last_a) chk("a_last_idle", last_a, 1'b0);
    if (val_b) begin
      if (qb.size() == 0) chk("b_spurious_beat", 1, 0);
      else begin
        chk("b_data", data_b, qb[0].d);
        chk("b_last", last_b, qb[0].l);
        chk("b_conv", conv_b, qb[0].c);
        chk("b_loop", oloop_b, qb[0].n);
        if (i_rdy) void'(qb.pop_front());
      end
    end
    if (drop_a) drops_a++;
    if (drop_b) chk("b_drop", drop_b, 1'b0);
  end
  initial begin
    logic [6:0] pat;
    int a0;
    pat = 7'b1101001;
    repeat (3) tick;
    @(negedge clk);
    chk("rst_val", {val_a, val_b}, 2'b00);
    chk("rst_data", {data_a, data_b}, 8'h00);
    chk("rst_flags", {last_a, conv_a, drop_a, last_b, conv_b, drop_b}, 6'h00);
    chk("rst_loop", {oloop_a, oloop_b}, 14'h0);
    tick;
    xrst = 1'b0;
    tick;
    // 1: converged pulse, latency one clock
    est_a = 16'hA5C3; loop_a = 7'd5; dec_a = 1'b1;
    push_a(16'hA5C3, 1'b1, 7'd5);
    @(negedge clk);
    chk("t1_lat0", val_a, 1'b0);
    tick;
    dec_a = 1'b0;
    @(negedge clk);
    chk("t1_lat1", val_a, 1'b1);
    wait_idle;
    // 2: iteration limit reached and held
    tick;
    for (int i = 17; i <= 20; i++) begin
      loop_a = 7'(i);
      if (i == 20) push_a(16'hA5C3, 1'b0, 7'd20);
      tick;
    end
    repeat (9) tick;
    loop_a = 7'd0;
    wait_idle;
    chk("t2_drop", drops_a, exp_drops);
    // 3: ten-bit vector, padded last beat
    tick;
    est_b = 10'b11_0101_1001; loop_b = 7'd7; dec_b = 1'b1;
    for (int k = 0; k < 3; k++) qb.push_back('{beat({6'h0, est_b}, k, 10), k == 2, 1'b1, 7'd7});
    tick;
    dec_b = 1'b0;
    wait_idle;
    // 4: backpressure pattern
    tick;
    a0 = acc_a;
    est_a = 16'hA5C3; loop_a = 7'd5; dec_a = 1'b1;
    push_a(16'hA5C3, 1'b1, 7'd5);
    tick;
    dec_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      i_rdy = pat[i];
      tick;
    end
    i_rdy = 1'b1;
    wait_idle;
    chk("t4_accepts", acc_a - a0, 4);
    // 5: dropped event mid-frame, then back-to-back capture on the last beat
    tick;
    est_a = 16'hA5C3; loop_a = 7'd5; dec_a = 1'b1;
    push_a(16'hA5C3, 1'b1, 7'd5);
    tick;
    dec_a = 1'b0;
    tick;
    est_a = 16'h1234; dec_a = 1'b1;
    exp_drops++;
    tick;
    dec_a = 1'b0;
    tick;
    est_a = 16'h9E7B; loop_a = 7'd9; dec_a = 1'b1;
    push_a(16'h9E7B, 1'b1, 7'd9);
    tick;
    dec_a = 1'b0;
    @(negedge clk);
    chk("t5_no_bubble", val_a, 1'b1);
    wait_idle;
    chk("t5_drop", drops_a, exp_drops);
    // 6: reset mid-frame, then a fresh frame
    tick;
    est_a = 16'h0F1E; loop_a = 7'd11; dec_a = 1'b1;
    push_a(16'h0F1E, 1'b1, 7'd11);
    tick;
    dec_a = 1'b0;
    tick;
    tick;
    xrst = 1'b1; i_rdy = 1'b0;
    tick;
    xrst = 1'b0; i_rdy = 1'b1;
    qa.delete();
    @(negedge clk);
    chk("t6_val", val_a, 1'b0);
    chk("t6_outs", {data_a, last_a, conv_a, drop_a, oloop_a}, 14'h0);
    tick;
    est_a = 16'h7C2D; loop_a = 7'd3; dec_a = 1'b1;
    push_a(16'h7C2D, 1'b1, 7'd3);
    tick;
    dec_a = 1'b0;
    wait_idle;
    chk("final_drop", drops_a, exp_drops);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
